// File: rtl/core_pkg.sv
// Shared definitions for the multicycle core: FSM states, compare operations,
// ISA opcode encoding, instruction field layout and small decode helpers.
package core_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, EXC} state_t;

  typedef enum logic [1:0] {CMP_NONE, CMP_EQ, CMP_GT, CMP_GE} cmp_op_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_BEQ = 4'hA;
  localparam logic [3:0] OP_BGT = 4'hB;
  localparam logic [3:0] OP_BGE = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;

  // Instruction word: opcode[31:28] rd[27:23] ra[22:18] rb[17:13] imm[12:0]
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 23;
  localparam int RA_MSB  = 22;
  localparam int RA_LSB  = 18;
  localparam int RB_MSB  = 17;
  localparam int RB_LSB  = 13;
  localparam int IMM_MSB = 12;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_JMP;
  endfunction

  function automatic logic is_mem(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_writeback(input logic [3:0] op);
    logic wb;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SLT, OP_LW: wb = 1'b1;
      default:                       wb = 1'b0;
    endcase
    return wb;
  endfunction

  function automatic cmp_op_t cmp_op_of(input logic [3:0] op);
    cmp_op_t c;
    case (op)
      OP_BEQ:  c = CMP_EQ;
      OP_BGT:  c = CMP_GT;
      OP_BGE:  c = CMP_GE;
      default: c = CMP_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/core_fsm.sv
// Instruction-sequencing state machine: state register plus next-state logic.
// Memory states wait on their ack; decode and execute can divert to EXC.
module core_fsm
  import core_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   imem_ack,
  input  logic   dmem_ack,
  input  logic   illegal,
  input  logic   mem_op,
  input  logic   misaligned,
  output state_t state
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (imem_ack) state_d = DECODE;
      DECODE:  state_d = illegal ? EXC : EXEC;
      EXEC: begin
        if (mem_op) begin
          state_d = misaligned ? EXC : MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM:     if (dmem_ack) state_d = WB;
      WB:      state_d = FETCH;
      EXC:     state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/multicycle_core.sv
// Multicycle core for the 4-bit-opcode ISA: each instruction walks through
// FETCH/DECODE/EXEC/[MEM]/WB with req/ack handshakes to both memories.
module multicycle_core
  import core_pkg::*;
#(
  parameter int          DATAWIDTH         = 32,
  parameter int          NUMREGS           = 32,
  parameter logic [31:0] RESET_PC          = 32'd0,
  parameter logic [31:0] EXCEPTION_ADDRESS = 32'd69,
  parameter int          CNT_WIDTH         = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 imem_req_o,
  output logic [31:0]          imem_addr_o,
  input  logic                 imem_ack_i,
  input  logic [31:0]          imem_rdata_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [DATAWIDTH-1:0] dmem_addr_o,
  output logic [DATAWIDTH-1:0] dmem_wdata_o,
  input  logic                 dmem_ack_i,
  input  logic [DATAWIDTH-1:0] dmem_rdata_i,
  output logic [31:0]          pc_o,
  output logic                 retire_o,
  output logic                 exception_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] instret_cnt_o
);

  localparam int IDX_W = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;
  localparam int SHW   = $clog2(DATAWIDTH);

  state_t               state;
  logic [31:0]          ir;
  logic [31:0]          pc_q;
  logic [31:0]          next_pc_q;
  logic [31:0]          next_pc;
  logic [31:0]          imm_pc;
  logic [DATAWIDTH-1:0] imm_d;
  logic [DATAWIDTH-1:0] a_q;
  logic [DATAWIDTH-1:0] b_q;
  logic [DATAWIDTH-1:0] r_q;
  logic [DATAWIDTH-1:0] operand;
  logic [DATAWIDTH-1:0] alu_res;
  logic [DATAWIDTH-1:0] regs [NUMREGS];
  logic [CNT_WIDTH-1:0] cycle_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic [3:0]           opcode;
  logic [IDX_W-1:0]     rd_idx;
  logic [IDX_W-1:0]     ra_idx;
  logic [IDX_W-1:0]     rb_idx;
  logic [IDX_W-1:0]     wb_idx;
  logic                 taken;
  logic                 misaligned;
  logic                 illegal_op;
  logic                 mem_op;
  logic                 fetch_active;
  logic                 mem_active;

  // Register indices wrap modulo NUMREGS so non-power-of-two banks stay in range.
  assign opcode     = ir[OPC_MSB:OPC_LSB];
  assign rd_idx     = IDX_W'(32'(ir[RD_MSB:RD_LSB]) % NUMREGS);
  assign ra_idx     = IDX_W'(32'(ir[RA_MSB:RA_LSB]) % NUMREGS);
  assign rb_idx     = IDX_W'(32'(ir[RB_MSB:RB_LSB]) % NUMREGS);
  assign wb_idx     = (opcode == OP_LW) ? rb_idx : rd_idx;
  assign imm_pc     = {{(32 - IMM_W){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
  assign imm_d      = {{(DATAWIDTH - IMM_W){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
  assign illegal_op = !is_legal(opcode);
  assign mem_op     = is_mem(opcode);
  assign misaligned = alu_res[1:0] != 2'b00;

  core_fsm u_fsm (
    .clk        (clk_i),
    .rst        (rst_i),
    .imem_ack   (imem_ack_i),
    .dmem_ack   (dmem_ack_i),
    .illegal    (illegal_op),
    .mem_op     (mem_op),
    .misaligned (misaligned),
    .state      (state)
  );

  always_comb begin
    operand = mem_op ? imm_d : b_q;
    alu_res = '0;
    case (opcode)
      OP_SUB:  alu_res = a_q - operand;
      OP_AND:  alu_res = a_q & operand;
      OP_OR:   alu_res = a_q | operand;
      OP_XOR:  alu_res = a_q ^ operand;
      OP_SLL:  alu_res = a_q << operand[SHW-1:0];
      OP_SRL:  alu_res = a_q >> operand[SHW-1:0];
      OP_SLT:  alu_res = {{(DATAWIDTH - 1){1'b0}}, $signed(a_q) < $signed(operand)};
      default: alu_res = a_q + operand;
    endcase
  end

  // Branch targets are relative to the branch's own PC.
  always_comb begin
    taken = 1'b0;
    unique case (cmp_op_of(opcode))
      CMP_EQ:  taken = (a_q == b_q);
      CMP_GT:  taken = ($signed(a_q) > $signed(b_q));
      CMP_GE:  taken = ($signed(a_q) >= $signed(b_q));
      default: taken = 1'b0;
    endcase
    next_pc = (taken || (opcode == OP_JMP)) ? (pc_q + imm_pc) : (pc_q + 32'd4);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      pc_q      <= RESET_PC;
      next_pc_q <= RESET_PC;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      case (state)
        FETCH:  if (imem_ack_i) ir <= imem_rdata_i;
        DECODE: begin
          a_q <= regs[ra_idx];
          b_q <= regs[rb_idx];
        end
        EXEC: begin
          r_q       <= alu_res;
          next_pc_q <= next_pc;
        end
        MEM:    if (dmem_ack_i && (opcode == OP_LW)) r_q <= dmem_rdata_i;
        WB: begin
          pc_q      <= next_pc_q;
          instret_q <= instret_q + 1'b1;
        end
        EXC:    pc_q <= EXCEPTION_ADDRESS;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUMREGS; i++) begin
        regs[i] <= '0;
      end
    end else if ((state == WB) && is_writeback(opcode)) begin
      regs[wb_idx] <= r_q;
    end
  end

  // Outputs are gated by reset so nothing is requested or pulsed while held.
  always_comb begin
    fetch_active  = !rst_i && (state == FETCH);
    mem_active    = !rst_i && (state == MEM);
    imem_req_o    = fetch_active;
    imem_addr_o   = fetch_active ? pc_q : '0;
    dmem_req_o    = mem_active;
    dmem_we_o     = mem_active && (opcode == OP_SW);
    dmem_addr_o   = mem_active ? r_q : '0;
    dmem_wdata_o  = (mem_active && (opcode == OP_SW)) ? b_q : '0;
    retire_o      = !rst_i && (state == WB);
    exception_o   = !rst_i && (state == EXC);
    pc_o          = pc_q;
    cycle_cnt_o   = cycle_q;
    instret_cnt_o = instret_q;
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: the bench plays both memories and
// predicts every handshake, PC and counter from an instruction-level model.
module tb_multicycle_core;
  import core_pkg::*;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam logic [31:0] EXC_PC = 32'd69;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        imem_req_o, dmem_req_o, dmem_we_o, retire_o, exception_o;
  logic [31:0] imem_addr_o, dmem_addr_o, dmem_wdata_o, pc_o;
  logic [31:0] cycle_cnt_o, instret_cnt_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] tb_cycles = '0;
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  logic [31:0] m_dmem [logic [31:0]];

  multicycle_core #(
    .DATAWIDTH(32), .NUMREGS(32), .RESET_PC(RST_PC),
    .EXCEPTION_ADDRESS(EXC_PC), .CNT_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack), .dmem_rdata_i(dmem_rdata),
    .pc_o(pc_o), .retire_o(retire_o), .exception_o(exception_o),
    .cycle_cnt_o(cycle_cnt_o), .instret_cnt_o(instret_cnt_o)
  );

  always #5 clk = ~clk;

  // Wall-clock cycle count since reset release, sampled only on negedges.
  always @(posedge clk) begin
    if (rst_i) tb_cycles = '0;
    else       tb_cycles = tb_cycles + 32'd1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input int rd, input int ra, input int rb,
                                      input logic [12:0] imm);
    return {op, 5'(rd), 5'(ra), 5'(rb), imm};
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] addr);
    if (!m_dmem.exists(addr)) m_dmem[addr] = $urandom;
    return m_dmem[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc      = RST_PC;
    m_instret = '0;
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    while (imem_req_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fetch_req", 64'(imem_req_o), 64'(1'b1));
  endtask

  // Runs one instruction end to end and checks it against the model.
  task automatic applyStimulus(input logic [31:0] instr, input int i_lat, input int d_lat);
    logic [3:0]  op;
    int          rd, ra, rb;
    logic [31:0] imm, a, b, addr, res, ld;
    bit          taken;
    op   = instr[31:28];
    rd   = int'(instr[27:23]);
    ra   = int'(instr[22:18]);
    rb   = int'(instr[17:13]);
    imm  = {{19{instr[12]}}, instr[12:0]};
    a    = m_regs[ra];
    b    = m_regs[rb];
    addr = a + imm;
    res  = '0;
    taken = 1'b0;
    case (op)
      OP_ADD: res = a + b;
      OP_SUB: res = a - b;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SLL: res = a << b[4:0];
      OP_SRL: res = a >> b[4:0];
      OP_SLT: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_BEQ: taken = (a == b);
      OP_BGT: taken = ($signed(a) > $signed(b));
      OP_BGE: taken = ($signed(a) >= $signed(b));
      OP_JMP: taken = 1'b1;
      default: ;
    endcase

    wait_fetch();
    checkOutput("fetch_addr", 64'(imem_addr_o), 64'(m_pc));
    checkOutput("pc", 64'(pc_o), 64'(m_pc));
    checkOutput("instret", 64'(instret_cnt_o), 64'(m_instret));
    checkOutput("cycle_cnt", 64'(cycle_cnt_o), 64'(tb_cycles));
    for (int i = 0; i < i_lat; i++) begin
      @(negedge clk);
      checkOutput("fetch_hold", {31'd0, imem_req_o, imem_addr_o}, {31'd0, 1'b1, m_pc});
    end
    imem_ack   = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;

    if (op > OP_JMP) begin
      @(negedge clk);
      checkOutput("illegal_exc", {61'd0, exception_o, retire_o, dmem_req_o}, 64'b100);
      m_pc = EXC_PC;
    end else if ((op == OP_LW || op == OP_SW) && addr[1:0] != 2'b00) begin
      @(negedge clk);
      checkOutput("misalign_exec_noreq", 64'(dmem_req_o), 64'd0);
      @(negedge clk);
      checkOutput("misalign_exc", {61'd0, exception_o, retire_o, dmem_req_o}, 64'b100);
      m_pc = EXC_PC;
    end else if (op == OP_LW || op == OP_SW) begin
      @(negedge clk);
      checkOutput("exec_noreq", 64'(dmem_req_o), 64'd0);
      @(negedge clk);
      checkOutput("mem_req", {30'd0, dmem_req_o, dmem_we_o, dmem_addr_o},
                  {30'd0, 1'b1, (op == OP_SW), addr});
      if (op == OP_SW) checkOutput("mem_wdata", 64'(dmem_wdata_o), 64'(b));
      for (int i = 0; i < d_lat; i++) begin
        @(negedge clk);
        checkOutput("mem_hold", {31'd0, dmem_req_o, dmem_addr_o}, {31'd0, 1'b1, addr});
      end
      ld = (op == OP_LW) ? mem_read(addr) : 32'($urandom);
      dmem_ack   = 1'b1;
      dmem_rdata = ld;
      @(negedge clk);
      dmem_ack   = 1'b0;
      checkOutput("mem_retire", {62'd0, retire_o, exception_o}, 64'b10);
      if (op == OP_SW) m_dmem[addr] = b;
      else             m_regs[rb] = ld;
      m_pc      = m_pc + 32'd4;
      m_instret = m_instret + 32'd1;
    end else begin
      @(negedge clk);
      checkOutput("exec_noreq", 64'(dmem_req_o), 64'd0);
      @(negedge clk);
      checkOutput("retire", {62'd0, retire_o, exception_o}, 64'b10);
      if (op <= OP_SLT) m_regs[rd] = res;
      m_pc      = taken ? (m_pc + imm) : (m_pc + 32'd4);
      m_instret = m_instret + 32'd1;
    end
  endtask

  initial begin
    logic [31:0] instr;
    logic [3:0]  op;
    logic [12:0] imm13;
    int          ra;

    model_reset();
    m_dmem[32'h10] = 32'd5;
    m_dmem[32'h14] = 32'd7;
    m_dmem[32'h18] = 32'h40;

    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_outputs", {59'd0, imem_req_o, dmem_req_o, dmem_we_o, retire_o, exception_o}, 64'd0);
    checkOutput("rst_addr", {imem_addr_o, dmem_addr_o}, 64'd0);
    checkOutput("rst_counters", {cycle_cnt_o, instret_cnt_o}, 64'd0);
    checkOutput("rst_pc", 64'(pc_o), 64'(RST_PC));
    rst_i = 1'b0;
    @(negedge clk);

    applyStimulus(enc(OP_SW, 0, 0, 5, 13'h0), 0, 0);
    applyStimulus(enc(OP_LW, 0, 0, 1, 13'h10), 0, 0);
    applyStimulus(enc(OP_LW, 0, 0, 2, 13'h14), 1, 2);
    applyStimulus(enc(OP_ADD, 3, 1, 2, 13'h0), 0, 0);
    applyStimulus(enc(OP_SW, 0, 0, 3, 13'h20), 0, 0);
    applyStimulus(enc(OP_LW, 0, 0, 1, 13'h18), 0, 0);
    applyStimulus(enc(OP_SW, 0, 1, 2, 13'h8), 0, 3);
    applyStimulus(enc(OP_LW, 0, 1, 4, 13'h8), 2, 3);
    applyStimulus(enc(OP_SW, 0, 0, 4, 13'h30), 0, 0);

    imm13 = 13'(32'h20 - m_pc);
    applyStimulus(enc(OP_JMP, 0, 0, 0, imm13), 0, 0);
    applyStimulus(enc(OP_BEQ, 0, 1, 1, 13'(-8)), 0, 0);
    applyStimulus(enc(OP_BEQ, 0, 1, 2, 13'(-8)), 0, 0);
    applyStimulus(enc(OP_SW, 0, 0, 3, 13'h34), 0, 0);

    applyStimulus({4'hE, 28'h0000123}, 0, 0);
    applyStimulus(enc(OP_LW, 0, 1, 4, 13'h1), 1, 0);
    applyStimulus(enc(OP_SW, 0, 0, 4, 13'h38), 0, 0);
    applyStimulus(enc(OP_BGT, 0, 1, 2, 13'h10), 0, 0);
    applyStimulus(enc(OP_BGE, 0, 2, 1, 13'h10), 0, 0);
    applyStimulus(enc(OP_SLT, 6, 2, 1, 13'h0), 0, 0);
    applyStimulus(enc(OP_SW, 0, 0, 6, 13'h3C), 0, 0);

    for (int k = 0; k < 60; k++) begin
      op    = 4'($urandom_range(0, 15));
      ra    = int'($urandom_range(0, 31));
      imm13 = 13'($urandom);
      if ((op == OP_LW || op == OP_SW) && $urandom_range(0, 3) != 0)
        imm13[1:0] = 2'd0 - m_regs[ra][1:0];
      instr = enc(op, int'($urandom_range(0, 31)), ra, int'($urandom_range(0, 31)), imm13);
      applyStimulus(instr, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    // Reset while a load is waiting in MEM with no ack coming.
    wait_fetch();
    imem_ack   = 1'b1;
    imem_rdata = enc(OP_LW, 0, 0, 6, 13'h10);
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_mem_req", 64'(dmem_req_o), 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_pc", 64'(pc_o), 64'(RST_PC));
    checkOutput("mid_reset_dreq", 64'(dmem_req_o), 64'd0);
    checkOutput("mid_reset_counters", {cycle_cnt_o, instret_cnt_o}, 64'd0);
    rst_i = 1'b0;
    model_reset();
    @(negedge clk);
    applyStimulus(enc(OP_SW, 0, 0, 1, 13'h40), 0, 0);
    applyStimulus(enc(OP_ADD, 7, 1, 2, 13'h0), 0, 0);
    wait_fetch();
    checkOutput("final_addr", 64'(imem_addr_o), 64'(m_pc));
    checkOutput("final_instret", 64'(instret_cnt_o), 64'(m_instret));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
